// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle arithmetic/logic/compare, iterative shifts
// (SHIFT_STEP bits per cycle) and an iterative shift-add multiplier (MUL_STEP bits per cycle).
module alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4,
  parameter int MUL_STEP   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_func,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_XOR  = 4'd4;
  localparam logic [3:0] F_SLT  = 4'd5;
  localparam logic [3:0] F_SLTU = 4'd6;
  localparam logic [3:0] F_SLL  = 4'd7;
  localparam logic [3:0] F_SRL  = 4'd8;
  localparam logic [3:0] F_SRA  = 4'd9;
  localparam logic [3:0] F_MUL  = 4'd10;

  localparam logic [CW-1:0] SSTEP  = CW'(SHIFT_STEP);
  localparam logic [CW-1:0] MSTEPS = CW'(XLEN / MUL_STEP);

  logic [1:0]      state;
  logic [3:0]      func_r;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [CW-1:0]   cnt;

  logic [CW-1:0]   sh_ext;
  logic [CW-1:0]   first_n;
  logic [CW-1:0]   busy_n;

  function automatic logic [XLEN-1:0] alu_simple(input logic [3:0] f,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return b - a;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      F_SLT:   return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLTU:  return {{(XLEN-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  // Partial shift of at most SHIFT_STEP bits; SRA keeps the MSB, which is the original sign.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0] f,
                                                 input logic [XLEN-1:0] v,
                                                 input logic [CW-1:0] n);
    case (f)
      F_SLL:   return v << n;
      F_SRL:   return v >> n;
      default: return $signed(v) >>> n;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] mul_step(input logic [XLEN-1:0] acc,
                                               input logic [XLEN-1:0] m,
                                               input logic [MUL_STEP-1:0] bits);
    logic [XLEN-1:0] r;
    r = acc;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (bits[i]) r = r + (m << i);
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign sh_ext  = {1'b0, in_b[SHW-1:0]};
  assign first_n = (sh_ext <= SSTEP) ? sh_ext : SSTEP;
  assign busy_n  = (cnt <= SSTEP) ? cnt : SSTEP;

  // The accept edge performs the first iteration, so latency equals the iteration count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      func_r   <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            func_r  <= in_func;
            out_err <= 1'b0;
            case (in_func)
              F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_SLTU: begin
                out_data <= alu_simple(in_func, in_a, in_b);
                state    <= DONE;
              end
              F_SLL, F_SRL, F_SRA: begin
                out_data <= shift_step(in_func, in_a, first_n);
                cnt      <= sh_ext - first_n;
                state    <= (sh_ext <= SSTEP) ? DONE : BUSY;
              end
              F_MUL: begin
                out_data <= mul_step('0, in_a, in_b[MUL_STEP-1:0]);
                mcand    <= in_a << MUL_STEP;
                mplier   <= in_b >> MUL_STEP;
                cnt      <= MSTEPS - 1'b1;
                state    <= (MSTEPS == 1) ? DONE : BUSY;
              end
              default: begin
                out_data <= '0;
                out_err  <= 1'b1;
                state    <= DONE;
              end
            endcase
          end
        end
        BUSY: begin
          if (func_r == F_MUL) begin
            out_data <= mul_step(out_data, mcand, mplier[MUL_STEP-1:0]);
            mcand    <= mcand << MUL_STEP;
            mplier   <= mplier >> MUL_STEP;
            cnt      <= cnt - 1'b1;
            if (cnt == 1) state <= DONE;
          end else begin
            out_data <= shift_step(func_r, out_data, busy_n);
            cnt      <= cnt - busy_n;
            if (cnt <= SSTEP) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int checks;
  int errors;
  logic [31:0] last_data;

  alu_seq #(.XLEN(32), .SHIFT_STEP(4), .MUL_STEP(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {err, data} from the operation definitions.
  function automatic logic [32:0] model(input logic [3:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    longint unsigned p;
    sh = b % 32;
    p  = 64'(a) * 64'(b);
    case (f)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, b - a};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, 32'($signed(a) < $signed(b))};
      4'd6:    return {1'b0, 32'(a < b)};
      4'd7:    return {1'b0, a << sh};
      4'd8:    return {1'b0, a >> sh};
      4'd9:    return {1'b0, 32'($signed(a) >>> sh)};
      4'd10:   return {1'b0, p[31:0]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] f, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if (f >= 4'd7 && f <= 4'd9) return (sh == 0) ? 1 : (sh + 3) / 4;
    if (f == 4'd10) return 16;
    return 1;
  endfunction

  task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [32:0] m;
    int lat;
    int exp_lat;
    logic ready_seen;
    m = model(f, a, b);
    exp_lat = model_lat(f, b);
    in_func = f; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_func = 4'($urandom);
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " data"}, out_data, m[31:0]);
    chk({tag, " err"}, 32'(out_err), 32'(m[32]));
    chk({tag, " ready_while_busy"}, 32'(ready_seen), 32'd0);
    last_data = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_func = 4'd0; in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold data"}, out_data, m[31:0]);
      chk({tag, " hold ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post valid"}, 32'(out_valid), 32'd0);
    chk({tag, " post ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_func = 4'd0; in_a = 32'd0; in_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);

    do_op(4'd0, 32'd5, 32'd7, 0, "add");
    chk("add const", last_data, 32'd12);
    do_op(4'd1, 32'd3, 32'd10, 0, "sub");
    chk("sub const", last_data, 32'd7);
    do_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    chk("slt const", last_data, 32'd1);
    do_op(4'd6, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
    chk("sltu const", last_data, 32'd0);
    do_op(4'd9, 32'h8000_0000, 32'd4, 0, "sra4");
    chk("sra4 const", last_data, 32'hF800_0000);
    do_op(4'd9, 32'h8000_0000, 32'd31, 0, "sra31");
    chk("sra31 const", last_data, 32'hFFFF_FFFF);
    do_op(4'd9, 32'h8000_0000, 32'h25, 0, "sra5");
    chk("sra5 const", last_data, 32'hFC00_0000);
    do_op(4'd7, 32'h1234_5678, 32'd0, 0, "sll0");
    do_op(4'd8, 32'h8765_4321, 32'd13, 0, "srl13");
    do_op(4'd10, 32'hFFFF_FFFF, 32'd3, 0, "mul");
    chk("mul const", last_data, 32'hFFFF_FFFD);
    do_op(4'd0, 32'h1111_1111, 32'h2222_2222, 5, "backpressure");
    do_op(4'd3, 32'h0000_00F0, 32'h0000_000F, 0, "or_after_bp");

    // Reset in the eighth BUSY cycle of a multiply.
    in_func = 4'd10; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_mul busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_mul rst valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_mul rel valid", 32'(out_valid), 32'd0);
    chk("mid_mul rel ready", 32'(in_ready), 32'd1);
    do_op(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 0, "xor");
    chk("xor const", last_data, 32'h0F0F_F0F0);

    do_op(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 0, "illegal");
    do_op(4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, "and_after_ill");

    for (int n = 0; n < 60; n++) begin
      logic [3:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      do_op(f, a, b, $urandom_range(0, 2), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
